// File: rtl/mips_instr_encoder_if.sv
// Request and memory-write bus of the MIPS instruction encoder.
// The master side issues micro-op requests and accepts memory writes.
interface mips_instr_encoder_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [4:0]    req_rs;
   logic [4:0]    req_rt;
   logic [4:0]    req_rd;
   logic [15:0]   req_imm;
   logic [25:0]   req_target;
   logic          req_last;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;

   modport master (
      output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target, req_last,
      input  req_ready,
      input  wr_valid, wr_addr, wr_data,
      output wr_ready
   );

   modport slave (
      input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, req_target, req_last,
      output req_ready,
      output wr_valid, wr_addr, wr_data,
      input  wr_ready
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes micro-op requests into MIPS words and streams them to program memory.
// state | meaning: IDLE wait start | RUN accept/encode | DRAIN flush last write | DONE session over
module mips_instr_encoder #(
   parameter int AW    = 32,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [AW-1:0]            base_addr,
   mips_instr_encoder_if.slave      bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_illegal,
   output logic                     busy,
   output logic                     done
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          wr_valid_q, wr_valid_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;

   logic [31:0]   enc_word;
   logic          enc_legal;
   logic [CW-1:0] inflight;
   logic          wr_fire;
   logic          req_ready_c;
   logic          accept;

   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      case (bus.req_op)
         4'd0:  enc_word = 32'h0;
         4'd1:  enc_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'b100000};
         4'd2:  enc_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'b100010};
         4'd3:  enc_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'b100100};
         4'd4:  enc_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'b100101};
         4'd5:  enc_word = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'b101010};
         4'd6:  enc_word = {6'b100011, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd7:  enc_word = {6'b101011, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd8:  enc_word = {6'b001000, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd9:  enc_word = {6'b001100, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd10: enc_word = {6'b000010, bus.req_target};
         4'd11: enc_word = {6'b000100, bus.req_rs, bus.req_rt, bus.req_imm};
         4'd12: enc_word = {6'b000101, bus.req_rs, bus.req_rt, bus.req_imm};
         default: enc_legal = 1'b0;
      endcase
   end

   // Words already committed to this session: written plus the one pending.
   assign inflight    = count_q + CW'(wr_valid_q);
   assign wr_fire     = wr_valid_q & bus.wr_ready;
   assign req_ready_c = (state_q == S_RUN) & (~wr_valid_q | bus.wr_ready) & (inflight < DEPTH_C);
   assign accept      = bus.req_valid & req_ready_c;

   always_comb begin
      state_d    = state_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      count_d    = count_q;
      err_d      = err_q;
      if (wr_fire) begin
         wr_valid_d = 1'b0;
         wr_addr_d  = wr_addr_q + AW'(4);
         count_d    = count_q + CW'(1);
      end
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_RUN;
               wr_addr_d = base_addr;
               count_d   = '0;
               err_d     = 1'b0;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (enc_legal) begin
                  wr_valid_d = 1'b1;
                  wr_data_d  = enc_word;
               end else begin
                  err_d = 1'b1;
               end
               if (bus.req_last || (enc_legal && ((inflight + CW'(1)) == DEPTH_C)))
                  state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!wr_valid_q || bus.wr_ready)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign count         = count_q;
   assign err_illegal   = err_q;
   assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed scenarios plus random traffic,
// checked every cycle against a queue-based session model.
module tb_mips_instr_encoder;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] count;
   logic          err_illegal, busy, done;

   mips_instr_encoder_if #(.AW(AW)) bus ();

   mips_instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus),
      .count(count), .err_illegal(err_illegal), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int          m_st, m_acc, m_cnt;
   bit          m_err;
   logic [31:0] m_next;
   logic [31:0] qa[$];
   logic [31:0] qd[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoding built from the opcode/func table with plain arithmetic.
   function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt, input int rd,
                                           input int imm, input int tgt, output bit legal);
      int rfunc[6]  = '{0, 32, 34, 36, 37, 42};
      int iopc[16]  = '{0, 0, 0, 0, 0, 0, 35, 43, 8, 12, 0, 4, 5, 0, 0, 0};
      longint w;
      legal = 1'b1;
      w = 0;
      if (op == 0)
         w = 0;
      else if (op <= 5)
         w = longint'(rs) * (2**21) + longint'(rt) * (2**16) + longint'(rd) * (2**11) + rfunc[op];
      else if (op == 10)
         w = longint'(2) * (2**26) + tgt;
      else if (op <= 12)
         w = longint'(iopc[op]) * (2**26) + longint'(rs) * (2**21) + longint'(rt) * (2**16) + imm;
      else
         legal = 1'b0;
      return w[31:0];
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_acc = 0; m_cnt = 0; m_err = 0; m_next = 0;
      qa.delete(); qd.delete();
   endtask

   task automatic step();
      bit          exp_rdy, fire, legal;
      logic [31:0] w;
      @(negedge clk);
      exp_rdy = (m_st == M_RUN) && (qd.size() == 0 || bus.wr_ready) && (m_acc < DEPTH);
      check("req_ready", bus.req_ready, exp_rdy);
      check("wr_valid", bus.wr_valid, qd.size() != 0);
      if (qd.size() != 0) begin
         check("wr_addr", bus.wr_addr, qa[0]);
         check("wr_data", bus.wr_data, qd[0]);
      end
      check("busy", busy, m_st == M_RUN || m_st == M_DRAIN);
      check("done", done, m_st == M_DONE);
      check("count", count, m_cnt);
      check("err_illegal", err_illegal, m_err);
      if (rst) begin
         model_reset();
      end else begin
         fire = (qd.size() != 0) && bus.wr_ready;
         case (m_st)
            M_IDLE, M_DONE: if (start) begin
               m_st = M_RUN; m_acc = 0; m_cnt = 0; m_err = 0; m_next = base_addr;
            end
            M_RUN: begin
               if (fire) begin void'(qa.pop_front()); void'(qd.pop_front()); m_cnt++; end
               if (bus.req_valid && exp_rdy) begin
                  w = ref_enc(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd,
                              bus.req_imm, bus.req_target, legal);
                  if (!legal) m_err = 1;
                  else begin
                     qa.push_back(m_next); qd.push_back(w);
                     m_next += 32'd4; m_acc++;
                  end
                  if (bus.req_last || m_acc == DEPTH) m_st = M_DRAIN;
               end
            end
            default: begin
               if (fire) begin void'(qa.pop_front()); void'(qd.pop_front()); m_cnt++; end
               if (qd.size() == 0) m_st = M_DONE;
            end
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int op, input int rs, input int rt, input int rd,
                          input int imm, input int tgt, input bit last);
      bus.req_valid  = 1'b1;
      bus.req_op     = 4'(op);
      bus.req_rs     = 5'(rs);
      bus.req_rt     = 5'(rt);
      bus.req_rd     = 5'(rd);
      bus.req_imm    = 16'(imm);
      bus.req_target = 26'(tgt);
      bus.req_last   = last;
   endtask

   task automatic do_start(input logic [31:0] base);
      start = 1'b1; base_addr = base;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0;
      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs = '0; bus.req_rt = '0; bus.req_rd = '0;
      bus.req_imm = '0; bus.req_target = '0; bus.req_last = 1'b0; bus.wr_ready = 1'b0;
      @(posedge clk); #1;
      model_reset();
      step();
      rst = 1'b0;
      check("rst_wr_addr", bus.wr_addr, 32'h0);
      check("rst_wr_data", bus.wr_data, 32'h0);
      step();

      // single ADD with last
      do_start(32'h400);
      set_req(1, 1, 2, 3, 16'hABCD, 26'h3FFFFFF, 1'b1);
      step();
      bus.req_valid = 1'b0;
      check("add_data", bus.wr_data, 32'h00221820);
      check("add_addr", bus.wr_addr, 32'h400);
      bus.wr_ready = 1'b1;
      step(); step();
      check("add_done", done, 1'b1);
      check("add_count", count, 1);

      // back-to-back stream
      do_start(32'h400);
      set_req(6, 0, 8, 0, 4, 0, 1'b0);       step();
      check("lw_data", bus.wr_data, 32'h8C080004);
      check("lw_addr", bus.wr_addr, 32'h400);
      set_req(11, 8, 9, 0, 16'hFFFF, 0, 1'b0); step();
      check("beq_data", bus.wr_data, 32'h1109FFFF);
      check("beq_addr", bus.wr_addr, 32'h404);
      set_req(10, 0, 0, 0, 0, 26'h100, 1'b1);  step();
      check("j_data", bus.wr_data, 32'h08000100);
      check("j_addr", bus.wr_addr, 32'h408);
      bus.req_valid = 1'b0;
      step(); step();
      check("stream_count", count, 3);

      // stall, illegal op, sequential address after illegal
      do_start(32'h1000);
      bus.wr_ready = 1'b0;
      set_req(1, 1, 2, 3, 0, 0, 1'b0); step();
      set_req(2, 7, 7, 7, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_data", bus.wr_data, 32'h00221820);
         check("stall_addr", bus.wr_addr, 32'h1000);
         check("stall_count", count, 0);
      end
      bus.req_valid = 1'b0; bus.wr_ready = 1'b1; step();
      check("release_count", count, 1);
      set_req(14, 3, 3, 3, 3, 3, 1'b0); step();
      check("illegal_err", err_illegal, 1'b1);
      check("illegal_nowr", bus.wr_valid, 1'b0);
      set_req(4, 4, 5, 6, 16'h1234, 0, 1'b0); step();
      check("or_data", bus.wr_data, 32'h00853025);
      check("or_addr", bus.wr_addr, 32'h1004);
      set_req(0, 31, 31, 31, 16'hFFFF, 26'h3FFFFFF, 1'b1); step();
      check("nop_data", bus.wr_data, 32'h0);
      check("nop_addr", bus.wr_addr, 32'h1008);
      bus.req_valid = 1'b0;
      step(); step();
      do_start(32'h2000);
      check("err_cleared", err_illegal, 1'b0);

      // depth limit without last
      for (int i = 0; i < 6; i++) begin
         set_req(8, i, i + 1, 0, i * 3, 0, 1'b0);
         step();
      end
      bus.req_valid = 1'b0;
      check("depth_count", count, DEPTH);
      check("depth_done", done, 1'b1);
      check("depth_ready", bus.req_ready, 1'b0);

      // reset mid-session with a pending write
      do_start(32'h3000);
      bus.wr_ready = 1'b0;
      set_req(3, 9, 10, 11, 0, 0, 1'b0); step();
      bus.req_valid = 1'b0;
      check("pre_rst_valid", bus.wr_valid, 1'b1);
      rst = 1'b1; step(); rst = 1'b0;
      check("mrst_valid", bus.wr_valid, 1'b0);
      check("mrst_addr", bus.wr_addr, 32'h0);
      check("mrst_data", bus.wr_data, 32'h0);
      check("mrst_count", count, 0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_ready", bus.req_ready, 1'b0);
      step();

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 5) == 0);
         base_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4))
                                                 : ($urandom & 32'hFFFFFFFC);
         set_req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), $urandom & 32'h3FFFFFF,
                 $urandom_range(0, 6) == 0);
         bus.req_valid = ($urandom_range(0, 9) < 7);
         bus.wr_ready  = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Program-loader block: the encoding end of the MIPS instruction interface consumed by the control-unit decoder.
- Accepts compact micro-op requests over a valid/ready handshake.
- Assembles each request into the 32-bit MIPS word whose opcode/func fields the decoder recognises.
- Streams the words into instruction memory at consecutive word addresses. Used at boot and by benches to populate program memory.

Parameters:
AW, 32, width of the memory byte address
DEPTH, 256, maximum number of words written per load session

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a load session (sampled in IDLE/DONE only)
base_addr  in  AW  byte address of first word, latched on start
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_op  in  4  micro-op code (see Behaviour)
req_rs  in  5  rs field
req_rt  in  5  rt field
req_rd  in  5  rd field (R-type only)
req_imm  in  16  immediate/offset (I-type only)
req_target  in  26  jump target (J only)
req_last  in  1  marks final request of session
wr_valid  out  1  memory write pending
wr_ready  in  1  memory accepts write when wr_valid & wr_ready
wr_addr  out  AW  byte address of pending word
wr_data  out  32  encoded instruction
count  out  clog2(DEPTH)+1  words written this session
err_illegal  out  1  sticky: illegal req_op seen this session
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE

Behaviour:
- Reset values: state=IDLE; wr_valid=0; wr_addr=0; wr_data=0; count=0; err_illegal=0; req_ready=0; busy=0; done=0. Reset mid-session drops any pending write.
- Encoding table (req_op -> word):
  - R-type, opcode 000000, fields rs|rt|rd, shamt=0: 1 ADD func 100000; 2 SUB 100010; 3 AND 100100; 4 OR 100101; 5 SLT 101010.
  - I-type, fields opcode|rs|rt|imm: 6 LW 100011; 7 SW 101011; 8 ADDI 001000; 9 ANDI 001100; 11 BEQ 000100; 12 BNE 000101.
  - 10 J: 000010|target.
  - 0 NOP: 32'h00000000.
  - 13-15 illegal.
  - Unused fields are forced to 0 regardless of inputs.
- FSM:
  - IDLE: start -> RUN; latch wr_addr=base_addr; count=0; err_illegal=0.
  - RUN: req_ready = (!wr_valid | wr_ready) & (count+wr_valid < DEPTH). Output register loads the encoded word on accept, so latency is 1 cycle from accept to wr_valid=1. On each write handshake: count+1; wr_addr+4 (wraps modulo 2^AW). An accepted req_last, or the DEPTH-th accepted word, -> DRAIN.
  - DRAIN: req_ready=0; when no write is pending (or it completes this cycle) -> DONE.
  - DONE: done=1; outputs hold; start -> RUN with the same latching as IDLE.
- start is ignored in RUN/DRAIN.
- Illegal op:
  - accepted (consumed), no write, err_illegal=1 (sticky until next start).
  - Still honours req_last.
- Write and accept in the same cycle (back-to-back): wr_valid stays 1 with the new word and address +4; full throughput of 1 word/cycle when wr_ready=1.
- wr_valid/wr_addr/wr_data stable while wr_valid & !wr_ready.

Test Plan:
- Reset, start base_addr=0x400, ADD rs=1 rt=2 rd=3 with req_last -> wr_data=0x00221820, wr_addr=0x400 one cycle after accept; then DONE, count=1.
- Stream LW rs=0 rt=8 imm=4, BEQ rs=8 rt=9 imm=0xFFFF, J target=0x100 with wr_ready=1 -> 0x8C080004 at 0x400, 0x1109FFFF at 0x404, 0x08000100 at 0x408 on consecutive cycles.
- wr_ready held 0 for 3 cycles with a word pending -> req_ready=0, wr_* stable, no count change; release -> single write.
- req_op=14 mid-stream -> no write, err_illegal=1, next valid op lands at the next sequential address; new start clears err_illegal.
- DEPTH=4, feed 6 requests without req_last -> exactly 4 writes, req_ready=0 thereafter, done=1, count=4.
- Assert rst while wr_valid=1 in RUN -> next cycle all outputs at reset values, no write issued.
